// File: rtl/rx_link_monitor.sv
// Receive-side link monitor: word history, saturating counters, link-state FSM
// with activity timeout and link_up qualifier, blink-coded status LEDs.
module rx_link_monitor #(
    parameter int W         = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16,
    parameter int BLINK_W   = 24,
    parameter int TIMEOUT   = 2**20,
    parameter int LINK_GOOD = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [W-1:0]             d_in_i,
    input  logic                     d_in_valid_i,
    input  logic                     reframe_i,
    input  logic [$clog2(DEPTH)-1:0] sel_i,
    input  logic                     clr_counts_i,
    output logic [W-1:0]             d_last_o,
    output logic [W-1:0]             d_hist_o,
    output logic [CNT_W-1:0]         byte_count_o,
    output logic [CNT_W-1:0]         reframe_count_o,
    output logic                     data_led_o,
    output logic                     reframe_led_o,
    output logic                     link_up_o
);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int GR_W  = $clog2(LINK_GOOD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);
    localparam logic [GR_W-1:0]  GR_MAX  = GR_W'(LINK_GOOD);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_REFRAME} state_t;

    state_t                  state_q, state_d;
    logic [DEPTH-1:0][W-1:0] hist_q, hist_d;
    logic [CNT_W-1:0]        byte_q, byte_d;
    logic [CNT_W-1:0]        rfc_q, rfc_d;
    logic [BLINK_W-1:0]      presc_q, presc_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [GR_W-1:0]         gr_q, gr_d;
    logic                    rf_q;
    logic                    dled_q, dled_d;
    logic                    rled_q, rled_d;
    logic                    link_q, link_d;

    logic activity, tmr_at_max, timeout, rf_rise;

    assign activity   = d_in_valid_i | reframe_i;
    assign tmr_at_max = (tmr_q == TMR_MAX);
    // Any activity this cycle pre-empts the timeout event.
    assign timeout    = tmr_at_max & ~activity;
    assign rf_rise    = reframe_i & ~rf_q;

    always_comb begin
        hist_d = hist_q;
        if (d_in_valid_i) begin
            hist_d[0] = d_in_i;
            for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
        end

        presc_d = presc_q + BLINK_W'(1);

        byte_d = byte_q;
        if (clr_counts_i)                         byte_d = '0;
        else if (d_in_valid_i && byte_q != CNT_MAX) byte_d = byte_q + CNT_W'(1);

        rfc_d = rfc_q;
        if (clr_counts_i)                   rfc_d = '0;
        else if (rf_rise && rfc_q != CNT_MAX) rfc_d = rfc_q + CNT_W'(1);

        tmr_d = tmr_q;
        if (activity)         tmr_d = '0;
        else if (!tmr_at_max) tmr_d = tmr_q + TMR_W'(1);

        // Reframe kills the good run even when a valid word lands alongside it.
        gr_d = gr_q;
        if (reframe_i || timeout)              gr_d = '0;
        else if (d_in_valid_i && gr_q != GR_MAX) gr_d = gr_q + GR_W'(1);

        link_d = (gr_d == GR_MAX);
    end

    always_comb begin
        state_d = state_q;
        dled_d  = 1'b0;
        rled_d  = 1'b0;
        if (d_in_valid_i)   state_d = S_DATA;
        else if (reframe_i) state_d = S_REFRAME;
        else if (timeout)   state_d = S_IDLE;

        case (state_d)
            S_DATA:    dled_d = presc_d[BLINK_W-1];
            S_REFRAME: rled_d = presc_d[BLINK_W-1];
            default:   ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            hist_q  <= '0;
            byte_q  <= '0;
            rfc_q   <= '0;
            presc_q <= '0;
            tmr_q   <= '0;
            gr_q    <= '0;
            rf_q    <= 1'b0;
            dled_q  <= 1'b0;
            rled_q  <= 1'b0;
            link_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            byte_q  <= byte_d;
            rfc_q   <= rfc_d;
            presc_q <= presc_d;
            tmr_q   <= tmr_d;
            gr_q    <= gr_d;
            rf_q    <= reframe_i;
            dled_q  <= dled_d;
            rled_q  <= rled_d;
            link_q  <= link_d;
        end
    end

    assign d_last_o        = hist_q[0];
    assign d_hist_o        = hist_q[sel_i];
    assign byte_count_o    = byte_q;
    assign reframe_count_o = rfc_q;
    assign data_led_o      = dled_q;
    assign reframe_led_o   = rled_q;
    assign link_up_o       = link_q;
endmodule

// File: tb/tb_rx_link_monitor.sv
// Directed bench for rx_link_monitor with small parameters so saturation,
// blink and timeout all occur within a few dozen cycles.
module tb_rx_link_monitor;
    localparam int W = 8, DEPTH = 4, CNT_W = 4, BLINK_W = 3, TIMEOUT = 16, LINK_GOOD = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [W-1:0]     d_in = '0;
    logic             d_in_valid = 1'b0;
    logic             reframe = 1'b0;
    logic [1:0]       sel = '0;
    logic             clr_counts = 1'b0;
    logic [W-1:0]     d_last, d_hist;
    logic [CNT_W-1:0] byte_count, reframe_count;
    logic             data_led, reframe_led, link_up;

    int n_vec = 0;
    int n_err = 0;

    // Reference blink: 3-bit free-running count since the last reset edge.
    logic [2:0] m_presc;
    always @(posedge clk) begin
        if (rst) m_presc <= '0;
        else     m_presc <= m_presc + 3'd1;
    end

    always #5 clk = ~clk;

    rx_link_monitor #(
        .W(W), .DEPTH(DEPTH), .CNT_W(CNT_W), .BLINK_W(BLINK_W),
        .TIMEOUT(TIMEOUT), .LINK_GOOD(LINK_GOOD)
    ) dut (
        .clk_i(clk), .rst_i(rst), .d_in_i(d_in), .d_in_valid_i(d_in_valid),
        .reframe_i(reframe), .sel_i(sel), .clr_counts_i(clr_counts),
        .d_last_o(d_last), .d_hist_o(d_hist), .byte_count_o(byte_count),
        .reframe_count_o(reframe_count), .data_led_o(data_led),
        .reframe_led_o(reframe_led), .link_up_o(link_up)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_vec++;
        if ({d_last, d_hist, byte_count, reframe_count, data_led, reframe_led, link_up} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got last=%h cnt=%0d rfc=%0d led=%b%b link=%b want all 0",
                     d_last, byte_count, reframe_count, data_led, reframe_led, link_up);
        end
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            n_vec++;
            if ({d_last, d_hist, byte_count, reframe_count, data_led, reframe_led, link_up} !== '0) begin
                n_err++;
                $display("FAIL idle_outputs cyc=%0d got last=%h cnt=%0d rfc=%0d led=%b%b link=%b want all 0",
                         c, d_last, byte_count, reframe_count, data_led, reframe_led, link_up);
            end
        end
    endtask

    task automatic test_data();
        logic [7:0] pat [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic       seen0, seen1;
        for (int k = 0; k < 5; k++) begin
            d_in = pat[k];
            d_in_valid = 1'b1;
            step();
            n_vec++;
            if (link_up !== (k >= 3)) begin
                n_err++;
                $display("FAIL data_link_up word=%0d got %b want %b", k + 1, link_up, (k >= 3));
            end
            n_vec++;
            if (d_last !== pat[k] || byte_count !== CNT_W'(k + 1)) begin
                n_err++;
                $display("FAIL data_push word=%0d got last=%h cnt=%0d want last=%h cnt=%0d",
                         k + 1, d_last, byte_count, pat[k], k + 1);
            end
        end
        d_in_valid = 1'b0;
        d_in = '0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            n_vec++;
            if (d_hist !== pat[4 - s]) begin
                n_err++;
                $display("FAIL data_hist sel=%0d got %h want %h", s, d_hist, pat[4 - s]);
            end
        end
        sel = '0;
        seen0 = 1'b0;
        seen1 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (data_led) seen1 = 1'b1; else seen0 = 1'b1;
            n_vec++;
            if (data_led !== m_presc[2] || reframe_led !== 1'b0) begin
                n_err++;
                $display("FAIL data_led cyc=%0d got d=%b r=%b want d=%b r=0", c, data_led, reframe_led, m_presc[2]);
            end
        end
        n_vec++;
        if (!(seen0 && seen1)) begin
            n_err++;
            $display("FAIL data_led_toggle got seen0=%b seen1=%b want both 1", seen0, seen1);
        end
    endtask

    task automatic test_reframe();
        logic seen1 = 1'b0;
        reframe = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) reframe = 1'b0;
            step();
            if (reframe_led) seen1 = 1'b1;
            n_vec++;
            if (reframe_count !== 4'd1 || byte_count !== 4'd5 || link_up !== 1'b0) begin
                n_err++;
                $display("FAIL reframe_counts cyc=%0d got rfc=%0d cnt=%0d link=%b want rfc=1 cnt=5 link=0",
                         c, reframe_count, byte_count, link_up);
            end
            n_vec++;
            if (reframe_led !== m_presc[2] || data_led !== 1'b0) begin
                n_err++;
                $display("FAIL reframe_led cyc=%0d got r=%b d=%b want r=%b d=0", c, reframe_led, data_led, m_presc[2]);
            end
        end
        n_vec++;
        if (!seen1) begin
            n_err++;
            $display("FAIL reframe_led_blink got never-high want at least one high");
        end
    endtask

    task automatic test_valid_with_reframe();
        d_in = 8'h66;
        d_in_valid = 1'b1;
        reframe = 1'b1;
        step();
        d_in_valid = 1'b0;
        reframe = 1'b0;
        n_vec++;
        if (byte_count !== 4'd6 || reframe_count !== 4'd2 || link_up !== 1'b0 || d_last !== 8'h66) begin
            n_err++;
            $display("FAIL both_counts got cnt=%0d rfc=%0d link=%b last=%h want cnt=6 rfc=2 link=0 last=66",
                     byte_count, reframe_count, link_up, d_last);
        end
        n_vec++;
        if (data_led !== m_presc[2] || reframe_led !== 1'b0) begin
            n_err++;
            $display("FAIL both_state got d=%b r=%b want d=%b r=0", data_led, reframe_led, m_presc[2]);
        end
    endtask

    task automatic test_saturate_clear();
        int exp_cnt;
        for (int i = 0; i < 20; i++) begin
            d_in = 8'(i);
            d_in_valid = 1'b1;
            step();
            exp_cnt = (7 + i > 15) ? 15 : 7 + i;
            n_vec++;
            if (byte_count !== CNT_W'(exp_cnt) || link_up !== (i >= 3)) begin
                n_err++;
                $display("FAIL sat_count i=%0d got cnt=%0d link=%b want cnt=%0d link=%b",
                         i, byte_count, link_up, exp_cnt, (i >= 3));
            end
        end
        d_in = 8'hA5;
        clr_counts = 1'b1;
        step();
        clr_counts = 1'b0;
        d_in_valid = 1'b0;
        n_vec++;
        if (byte_count !== 4'd0 || reframe_count !== 4'd0) begin
            n_err++;
            $display("FAIL clr_wins got cnt=%0d rfc=%0d want 0 0", byte_count, reframe_count);
        end
        n_vec++;
        if (d_last !== 8'hA5 || link_up !== 1'b1) begin
            n_err++;
            $display("FAIL clr_keeps_state got last=%h link=%b want last=a5 link=1", d_last, link_up);
        end
        sel = 2'd3;
        #1;
        n_vec++;
        if (d_hist !== 8'h11) begin
            n_err++;
            $display("FAIL clr_hist sel=3 got %h want 11", d_hist);
        end
        sel = '0;
    endtask

    task automatic test_timeout();
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 1) begin
                n_vec++;
                if (byte_count !== 4'd0) begin
                    n_err++;
                    $display("FAIL tmo_cnt_held got %0d want 0", byte_count);
                end
            end
            if (c == 15) begin
                n_vec++;
                if (link_up !== 1'b1 || reframe_led !== 1'b0 || data_led !== m_presc[2]) begin
                    n_err++;
                    $display("FAIL tmo_before got link=%b d=%b r=%b want link=1 d=%b r=0",
                             link_up, data_led, reframe_led, m_presc[2]);
                end
            end
        end
        n_vec++;
        if (link_up !== 1'b0 || data_led !== 1'b0 || reframe_led !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_idle got link=%b d=%b r=%b want 0 0 0", link_up, data_led, reframe_led);
        end
        for (int c = 0; c < 8; c++) begin
            step();
            n_vec++;
            if (data_led !== 1'b0 || reframe_led !== 1'b0 || link_up !== 1'b0) begin
                n_err++;
                $display("FAIL tmo_stay_idle cyc=%0d got d=%b r=%b link=%b want 0 0 0",
                         c, data_led, reframe_led, link_up);
            end
        end
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 3; i++) begin
            d_in = 8'h5A + 8'(i);
            d_in_valid = 1'b1;
            step();
        end
        d_in_valid = 1'b0;
        reframe = 1'b1;
        step();
        reframe = 1'b0;
        d_in = 8'hFF;
        d_in_valid = 1'b1;
        reframe = 1'b1;
        clr_counts = 1'b0;
        rst = 1'b1;
        step();
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            n_vec++;
            if ({d_last, d_hist, byte_count, reframe_count, data_led, reframe_led, link_up} !== '0) begin
                n_err++;
                $display("FAIL midrun_reset sel=%0d got last=%h hist=%h cnt=%0d rfc=%0d led=%b%b link=%b want all 0",
                         s, d_last, d_hist, byte_count, reframe_count, data_led, reframe_led, link_up);
            end
        end
        sel = '0;
        rst = 1'b0;
        d_in_valid = 1'b0;
        reframe = 1'b0;
        d_in = '0;
        step();
        n_vec++;
        if ({d_last, byte_count, reframe_count, data_led, reframe_led, link_up} !== '0) begin
            n_err++;
            $display("FAIL post_reset got last=%h cnt=%0d rfc=%0d led=%b%b link=%b want all 0",
                     d_last, byte_count, reframe_count, data_led, reframe_led, link_up);
        end
    endtask

    initial begin
        test_reset();
        test_data();
        test_reframe();
        test_valid_with_reframe();
        test_saturate_clear();
        test_timeout();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
